// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared RISC-V constants used by the branch prediction unit.
//   OP_BRANCH      : conditional branch major opcode
//   F3_*           : branch condition encodings carried in funct3
//   CNT_RESET      : 2-bit predictor counter value after reset (weakly not-taken)
//   sat_next()     : 2-bit saturating counter step
//   f3_is_branch() : funct3 is one of the six defined branch conditions
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CNT_RESET = 2'b01;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return nxt;
  endfunction

  function automatic logic f3_is_branch(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: ok = 1'b1;
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp -- combinational branch condition evaluation.
//   funct3 : branch condition encoding
//   rs1    : first compare operand (XLEN)
//   rs2    : second compare operand (XLEN)
//   taken  : condition holds; 0 for undefined funct3 encodings
module branch_cmp
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  // Select the comparison named by funct3 over the full operand width
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit -- bimodal branch predictor with EX-stage resolution.
//   Build macro BRANCH_PREDICT_EN: when defined, a BHT of 2-bit saturating
//   counters drives pred_taken; when undefined, pred_taken is constant 0.
//   clk, rst                      : clock, async active-high reset
//   if_pc        -> pred_taken    : fetch lookup (combinational)
//   ex_valid/op/funct3/pc/pred_taken, ex_rs1/ex_rs2 : EX-stage branch inputs
//   br_taken                      : resolved outcome (combinational)
//   mispredict                    : registered one-cycle flush request
//   br_count, miss_count          : resolved-branch / mispredict counters
module branch_predict_unit
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [6:0]      ex_op,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  output logic            br_taken,
  output logic            mispredict,
  output logic [31:0]     br_count,
  output logic [31:0]     miss_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic        cmp_taken_s;
  logic        is_branch_s;
  logic        miss_s;
  logic        mispredict_r;
  logic [31:0] br_count_r;
  logic [31:0] miss_count_r;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .taken  (cmp_taken_s)
  );

  // Decode a valid conditional branch and flag a wrong prediction
  always_comb begin
    is_branch_s = 1'b0;
    miss_s      = 1'b0;
    if (ex_valid && (ex_op == OP_BRANCH) && f3_is_branch(ex_funct3)) begin
      is_branch_s = 1'b1;
      miss_s      = (cmp_taken_s != ex_pred_taken);
    end else begin
      is_branch_s = 1'b0;
      miss_s      = 1'b0;
    end
  end

  assign br_taken = is_branch_s & cmp_taken_s;

  // Flush pulse and performance counters, all landing the cycle after resolution
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_r <= 1'b0;
      br_count_r   <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      mispredict_r <= miss_s;
      if (is_branch_s) begin
        br_count_r <= br_count_r + 32'd1;
      end
      if (miss_s) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign mispredict = mispredict_r;
  assign br_count   = br_count_r;
  assign miss_count = miss_count_r;

`ifdef BRANCH_PREDICT_EN
  logic [1:0]       bht_r [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic             unused_pc_s;

  // Word-aligned PCs: bits [1:0] never select an entry
  assign if_idx_s    = if_pc[IDX_W+1:2];
  assign ex_idx_s    = ex_pc[IDX_W+1:2];
  assign unused_pc_s = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                         ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // Counter table; a same-index lookup sees the value before this edge's update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_r[i] <= CNT_RESET;
      end
    end else if (is_branch_s) begin
      bht_r[ex_idx_s] <= sat_next(bht_r[ex_idx_s], cmp_taken_s);
    end
  end

  assign pred_taken = bht_r[if_idx_s][1];
`else
  logic unused_pc_s;

  // Static not-taken: the PCs play no part in prediction
  assign unused_pc_s = ^{if_pc, ex_pc};
  assign pred_taken  = 1'b0;
`endif

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 64: number of branch history table entries, power of two, 2..1024.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port if_pc, input, XLEN: fetch PC for prediction lookup.
REQ-006 SHALL have port pred_taken, output, 1: combinational prediction for if_pc.
REQ-007 SHALL have port ex_valid, input, 1: EX-stage instruction valid.
REQ-008 SHALL have port ex_op, input, 7: EX opcode.
REQ-009 SHALL have port ex_funct3, input, 3: EX branch condition.
REQ-010 SHALL have port ex_pc, input, XLEN: EX-stage PC, used for the table update index.
REQ-011 SHALL have port ex_pred_taken, input, 1: prediction carried down the pipeline with the instruction.
REQ-012 SHALL have ports ex_rs1 and ex_rs2, input, XLEN each: compare operands.
REQ-013 SHALL have port br_taken, output, 1: combinational resolved outcome.
REQ-014 SHALL have port mispredict, output, 1: registered one-cycle flush request.
REQ-015 SHALL have ports br_count and miss_count, output, 32 each: performance counters.

Function
REQ-016 SHALL decode a branch as ex_valid=1, ex_op=1100011 and ex_funct3 in {000,001,100,101,110,111}.
REQ-017 SHALL resolve br_taken by funct3: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU, computed on full XLEN operands.
REQ-018 SHALL drive br_taken=0 for a non-branch, an invalid funct3 (010/011) or ex_valid=0; none of these update any state.
REQ-019 SHALL index the table with pc[log2(BHT_DEPTH)+1:2] for both lookup and update.
REQ-020 SHALL hold one 2-bit saturating counter per entry; pred_taken equals bit 1 of the entry indexed by if_pc.
REQ-021 SHALL, on a resolved branch, update the counter at the next edge: +1 if taken (saturate at 3), -1 if not taken (saturate at 0).
REQ-022 SHALL, when lookup and update hit the same index in the same cycle, return the pre-update value to pred_taken (no bypass).
REQ-023 SHALL assert mispredict for exactly the cycle after a resolved branch where br_taken != ex_pred_taken; otherwise 0. Back-to-back branches give independent pulses.
REQ-024 SHALL increment br_count on every resolved branch and miss_count on every mispredict event, both in the cycle after resolution, wrapping from FFFFFFFF to 0.

Reset
REQ-025 SHALL, on rst assertion at any time, set every counter to 01 (weakly not-taken), mispredict=0, br_count=0, miss_count=0; an update in flight is discarded.
REQ-026 SHALL hold all state at reset values while rst=1; combinational outputs remain functional.

Configuration
REQ-027 SHALL, with BRANCH_PREDICT_EN defined, implement the table as specified.
REQ-028 SHALL, without BRANCH_PREDICT_EN, omit the table: pred_taken is constant 0 (static not-taken); resolution, mispredict and counters are unchanged.

Structure
REQ-029 SHALL take the OP_BRANCH opcode constant, the six funct3 constants and the 2-bit counter reset value from the shared package riscv_pkg.
REQ-030 SHALL place the combinational condition evaluation in one sub-module, branch_cmp (funct3, rs1, rs2 -> taken).

Verification
REQ-031 SHALL cover the following directed scenarios:
- After reset, any if_pc -> pred_taken=0; br_count=0, miss_count=0, mispredict=0.
- BEQ rs1=5 rs2=5 at ex_pc=0x100, ex_pred_taken=0 -> br_taken=1; next cycle mispredict=1, br_count=1, miss_count=1; if_pc=0x100 then gives pred_taken=1.
- BLT rs1=0xFFFFFFFF rs2=1 -> taken; BLTU with the same operands -> not taken.
- Four taken resolutions at 0x200 -> counter saturates at 3; one not-taken -> counter=2, pred_taken stays 1.
- funct3=010 with ex_op=1100011 -> br_taken=0, no counter update, no mispredict.
- rst pulsed mid-stream after br_count=7 -> all counters back to 01, br_count=0, no mispredict pulse after release.
